// File: rtl/scan_pkg.sv
// scan_pkg: state encoding shared by the min/max streaming scan engines.
package scan_pkg;

    // SCAN collects a frame of candidates; DONE presents the result until taken.
    typedef enum logic {
        SCAN = 1'b0,
        DONE = 1'b1
    } scan_state_t;

endpackage : scan_pkg

// File: rtl/max_scan_cmp.sv
// max_cmp: combinational strict greater-than used in the argmax update path.
// Build option: MAX_SCAN_SIGNED_EN selects two's-complement comparison,
// otherwise both operands are treated as unsigned LENGTH-bit values.
module max_cmp #(
    parameter int LENGTH = 10
) (
    input  logic [LENGTH-1:0] a,
    input  logic [LENGTH-1:0] b,
    output logic              a_gt_b
);

`ifdef MAX_SCAN_SIGNED_EN
    // Signed build: compare as two's-complement at the native width.
    always_comb begin
        a_gt_b = $signed(a) > $signed(b);
    end
`else
    // Unsigned build: plain magnitude comparison at the native width.
    always_comb begin
        a_gt_b = a > b;
    end
`endif

endmodule : max_cmp

// File: rtl/max_scan.sv
// max_scan: streaming argmax over frames of 2**WIDTH candidates.
// Build option: MAX_SCAN_SIGNED_EN (in max_cmp) makes the comparison signed;
// handshake, tie rule and timing are unchanged by it.
module max_scan
    import scan_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int LENGTH = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LENGTH-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_index,
    output logic [LENGTH-1:0] out_value
);

    localparam logic [WIDTH-1:0] CNT_LAST = '1;

    scan_state_t       state_q, state_d;
    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  best_index_q, best_index_d;
    logic [LENGTH-1:0] best_value_q, best_value_d;
    logic              new_is_greater;

    max_cmp #(
        .LENGTH (LENGTH)
    ) u_cmp (
        .a      (in_data),
        .b      (best_value_q),
        .a_gt_b (new_is_greater)
    );

    // Next-state logic: accept beats in SCAN, track the running maximum, hand off in DONE.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        best_index_d = best_index_q;
        best_value_d = best_value_q;
        case (state_q)
            SCAN: begin
                if (in_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    // The first beat seeds the maximum regardless of its value;
                    // later beats replace it only when strictly larger, so ties
                    // keep the earlier index.
                    if (cnt_q == '0) begin
                        best_value_d = in_data;
                        best_index_d = '0;
                    end else if (new_is_greater) begin
                        best_value_d = in_data;
                        best_index_d = cnt_q;
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = SCAN;
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    // State, beat counter and result registers; reset discards any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= SCAN;
            cnt_q        <= '0;
            best_index_q <= '0;
            best_value_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            best_index_q <= best_index_d;
            best_value_q <= best_value_d;
        end
    end

    // Outputs come straight from registers; in_ready is held low during reset.
    always_comb begin
        in_ready  = (state_q == SCAN) && !rst;
        out_valid = (state_q == DONE);
        out_index = best_index_q;
        out_value = best_value_q;
    end

endmodule : max_scan

// File: tb/tb_max_scan.sv
// tb_max_scan: directed self-checking bench for max_scan (WIDTH=3, LENGTH=10).
module tb_max_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [9:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] out_index;
    logic [9:0] out_value;

    int checks = 0;
    int failures = 0;
    int last_waits = 0;
    logic [9:0] frame_vals [8];

    max_scan #(
        .WIDTH  (3),
        .LENGTH (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_value (out_value)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded wait).
    task automatic send_beat(input logic [9:0] v);
        int waits;
        waits = 0;
        in_valid = 1'b1;
        in_data  = v;
        while (!in_ready && waits < 20) begin
            tick();
            waits++;
        end
        last_waits = waits;
        checks++;
        if (!in_ready) begin
            failures++;
            $display("[TB] FAIL beat_accept_timeout got in_ready=%0b want 1", in_ready);
        end
        tick();
    endtask

    // Stream frame_vals (optionally with idle gaps) and check the latched result.
    task automatic run_frame(input string name, input bit gaps,
                             input logic [2:0] exp_idx, input logic [9:0] exp_val);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL %s_early_valid got %0b want 0", name, out_valid);
                end
            end
            send_beat(frame_vals[i]);
            if (gaps && i != 7) begin
                in_valid = 1'b0;
                in_data  = 10'd1000;
                tick();
            end
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL %s_valid got %0b want 1", name, out_valid);
        end
        checks++;
        if (out_index !== exp_idx) begin
            failures++;
            $display("[TB] FAIL %s_index got %0d want %0d", name, out_index, exp_idx);
        end
        checks++;
        if (out_value !== exp_val) begin
            failures++;
            $display("[TB] FAIL %s_value got %0d want %0d", name, out_value, exp_val);
        end
    endtask

    // Take the result and confirm the engine returns to SCAN.
    task automatic finish_frame(input string name);
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL %s_release got valid=%0b ready=%0b want valid=0 ready=1",
                     name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_index !== 3'd0 || out_value !== 10'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got ready=%0b valid=%0b idx=%0d val=%0d want 0 0 0 0",
                     in_ready, out_valid, out_index, out_value);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_release_ready got %0b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        frame_vals = '{10'd5, 10'd9, 10'd3, 10'd700, 10'd2, 10'd700, 10'd1, 10'd0};
        run_frame("basic", 1'b0, 3'd3, 10'd700);
        finish_frame("basic");
    endtask

    task automatic test_all_max();
        out_ready = 1'b1;
        frame_vals = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF};
        run_frame("all_max", 1'b0, 3'd0, 10'd1023);
        finish_frame("all_max");
    endtask

    task automatic test_gaps();
        out_ready = 1'b1;
        frame_vals = '{10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7, 10'd8};
        run_frame("gaps", 1'b1, 3'd7, 10'd8);
        finish_frame("gaps");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        frame_vals = '{10'd10, 10'd11, 10'd12, 10'd13, 10'd900, 10'd14, 10'd15, 10'd16};
        run_frame("bp", 1'b0, 3'd4, 10'd900);
        in_valid = 1'b1;
        in_data  = 10'd1023;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_index !== 3'd4 || out_value !== 10'd900) begin
                failures++;
                $display("[TB] FAIL bp_hold_cycle%0d got ready=%0b valid=%0b idx=%0d val=%0d want 0 1 4 900",
                         c, in_ready, out_valid, out_index, out_value);
            end
        end
        in_valid = 1'b0;
        finish_frame("bp");
        frame_vals = '{10'd50, 10'd1, 10'd1, 10'd1, 10'd1, 10'd1, 10'd1, 10'd1};
        run_frame("bp_next", 1'b0, 3'd0, 10'd50);
        finish_frame("bp_next");
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_beat(10'd1000);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_outputs got ready=%0b valid=%0b want 0 0", in_ready, out_valid);
        end
        tick();
        rst = 1'b0;
        #1;
        frame_vals = '{10'd10, 10'd20, 10'd30, 10'd40, 10'd50, 10'd60, 10'd70, 10'd5};
        run_frame("midreset", 1'b0, 3'd6, 10'd70);
        finish_frame("midreset");
    endtask

    task automatic test_signed();
        logic [2:0] e_idx;
        logic [9:0] e_val;
`ifdef MAX_SCAN_SIGNED_EN
        e_idx = 3'd3;
        e_val = 10'h1FF;
`else
        e_idx = 3'd0;
        e_val = 10'h3FF;
`endif
        out_ready = 1'b1;
        frame_vals = '{10'h3FF, 10'h200, 10'h000, 10'h1FF, 10'h000, 10'h000, 10'h000, 10'h000};
        run_frame("signedness", 1'b0, e_idx, e_val);
        finish_frame("signedness");
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        frame_vals = '{10'd3, 10'd1, 10'd4, 10'd1, 10'd5, 10'd9, 10'd2, 10'd6};
        run_frame("b2b_a", 1'b0, 3'd5, 10'd9);
        frame_vals = '{10'd8, 10'd8, 10'd2, 10'd7, 10'd1, 10'd8, 10'd2, 10'd8};
        send_beat(frame_vals[0]);
        checks++;
        if (last_waits != 1) begin
            failures++;
            $display("[TB] FAIL b2b_gap got %0d wait cycles want 1", last_waits);
        end
        for (int i = 1; i < 8; i++) begin
            send_beat(frame_vals[i]);
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_index !== 3'd0 || out_value !== 10'd8) begin
            failures++;
            $display("[TB] FAIL b2b_b_result got valid=%0b idx=%0d val=%0d want 1 0 8",
                     out_valid, out_index, out_value);
        end
        finish_frame("b2b_b");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_max();
        test_gaps();
        test_backpressure();
        test_reset_mid();
        test_signed();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_max_scan
